// File: rtl/csa_pkg.sv
// Shared constants, FSM state type and index-width helper for the
// carry-select multi-word sequencer.
package csa_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the chunk index; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/csa_slice8.sv
// 8-bit carry-select adder: rippled low nibble, high nibble precomputed for
// both carry values and selected by the low-nibble carry.
module csa_slice8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] c;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum[7:4] = c[4] ? hi1[3:0] : hi0[3:0];
  assign cout     = c[4] ? hi1[4]   : hi0[4];

endmodule

// File: rtl/csa_multiword_sequencer.sv
// Wide add (and optional subtract, macro CSA_SEQ_SUBTRACT_EN) computed one
// 8-bit chunk per cycle through a single shared carry-select slice.
module csa_multiword_sequencer
  import csa_pkg::*;
#(
  parameter int N_CHUNKS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          ready,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   a,
  input  logic [CHUNK_W*N_CHUNKS-1:0]   b,
  input  logic                          cin,
`ifdef CSA_SEQ_SUBTRACT_EN
  input  logic                          sub,
`endif
  output logic [CHUNK_W*N_CHUNKS-1:0]   sum,
  output logic                          cout,
  output logic                          overflow,
  output logic                          done
);

  localparam int W     = CHUNK_W * N_CHUNKS;
  localparam int IDX_W = clog2(N_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     opa_reg, opb_reg, sum_reg;
  logic             carry_reg, cout_reg, ovf_reg;
  logic             sub_eff, accept;
  logic [CHUNK_W-1:0] slice_sum;
  logic             slice_cout;

`ifdef CSA_SEQ_SUBTRACT_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept = start && (state_reg == IDLE);

  csa_slice8 u_slice (
    .a    (opa_reg[idx_reg*CHUNK_W +: CHUNK_W]),
    .b    (opb_reg[idx_reg*CHUNK_W +: CHUNK_W]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        // Subtraction is A + ~B + 1, so B is inverted once at latch time.
        opa_reg   <= a;
        opb_reg   <= sub_eff ? ~b : b;
        carry_reg <= sub_eff ? 1'b1 : cin;
        idx_reg   <= '0;
      end
      if (state_reg == RUN) begin
        sum_reg[idx_reg*CHUNK_W +: CHUNK_W] <= slice_sum;
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          cout_reg <= slice_cout;
          ovf_reg  <= (opa_reg[W-1] == opb_reg[W-1]) &&
                      (slice_sum[CHUNK_W-1] != opa_reg[W-1]);
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_csa_multiword_sequencer.sv
// Directed, table-driven bench for csa_multiword_sequencer (32-bit, 4 chunks).
module tb_csa_multiword_sequencer;

  localparam int N = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

`ifdef CSA_SEQ_SUBTRACT_EN
  localparam int NV = 9;
`else
  localparam int NV = 6;
`endif

  logic        clk = 1'b0;
  logic        reset, start, cin;
  logic [31:0] a, b;
  logic        ready, cout, overflow, done;
  logic [31:0] sum;
`ifdef CSA_SEQ_SUBTRACT_EN
  logic        sub;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  vec_t vecs[NV];

  csa_multiword_sequencer #(.N_CHUNKS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ready    (ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef CSA_SEQ_SUBTRACT_EN
    .sub      (sub),
`endif
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    cin = v.cin;
`ifdef CSA_SEQ_SUBTRACT_EN
    sub = v.sub;
`endif
  endtask

  task automatic do_op(input vec_t v, input bit busy, input string tag);
    int lat;
    int rdy_hi;
    int extra;
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(ready), 32'd1);
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 1;
    rdy_hi = 0;
    if (busy) begin
      a = 32'h1111_1111; b = 32'h1111_1111; cin = 1'b1;
    end
    while (!done && lat < 20) begin
      if (ready) rdy_hi++;
      if (busy) start = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy) start = 1'b1;
    chk({tag, ".latency"}, 32'(lat), 32'(N + 1));
    chk({tag, ".ready_busy"}, 32'(rdy_hi + int'(ready)), 32'd0);
    chk({tag, ".sum"}, sum, v.s);
    chk({tag, ".cout"}, 32'(cout), 32'(v.c));
    chk({tag, ".ovf"}, 32'(overflow), 32'(v.o));
    $display("op %s: a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b lat=%0d",
             tag, v.a, v.b, v.cin, v.sub, sum, cout, overflow, lat);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".ready_after"}, 32'(ready), 32'd1);
    if (busy) begin
      extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done || !ready) extra++;
      end
      chk({tag, ".no_second_op"}, 32'(extra), 32'd0);
      chk({tag, ".sum_hold"}, sum, v.s);
    end
  endtask

  initial begin
    vec_t v;
    int t_done[3];
    int k;
    int guard;
    int seen;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
`ifdef CSA_SEQ_SUBTRACT_EN
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
`endif

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CSA_SEQ_SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", sum, 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < NV; i++) do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Start pulses while busy must not disturb the running operation.
    do_op(vecs[4], 1'b1, "busy");

    // Reset during the second RUN cycle discards the partial result.
    @(negedge clk);
    v = '{32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.ready", 32'(ready), 32'd1);
    chk("midrst.sum", sum, 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst.no_done", 32'(seen), 32'd0);
    $display("op midrst: reset in RUN, sum=%h ready=%0b", sum, ready);
    v = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
    do_op(v, 1'b0, "after_rst");

    // Start held high: one operation every N+2 cycles with current operands.
    @(negedge clk);
    drive(vecs[0]);
    start = 1'b1;
    k = 0;
    guard = 0;
    while (k < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (done) begin
        t_done[k] = cyc;
        chk($sformatf("b2b%0d.sum", k), sum, vecs[k].s);
        chk($sformatf("b2b%0d.cout", k), 32'(cout), 32'(vecs[k].c));
        chk($sformatf("b2b%0d.ovf", k), 32'(overflow), 32'(vecs[k].o));
        $display("op b2b%0d: sum=%h cout=%0b ovf=%0b cycle=%0d", k, sum, cout, overflow, cyc);
        k++;
        if (k < 3) drive(vecs[k]);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b.count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b.gap01", 32'(t_done[1] - t_done[0]), 32'(N + 2));
      chk("b2b.gap12", 32'(t_done[2] - t_done[1]), 32'(N + 2));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_multiword_sequencer.md
Name: csa_multiword_sequencer

Overview:
- Multi-cycle controller that performs 32-bit add/subtract by time-sharing one 8-bit carry-select adder slice.
- Operands are latched on a start handshake; the slice processes one 8-bit chunk per cycle, least-significant chunk first.
- The carry is registered between chunks.
- Sits in the ALU next to the single-cycle adders and serves wide or multi-precision operations where area matters more than latency.

Parameters:
- CHUNK_W, 8, width of the shared adder slice; fixed at 8 and not meant to be overridden.
- N_CHUNKS, 4, number of chunks per operation; operand width = CHUNK_W*N_CHUNKS; legal range 2..16.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; an operation is accepted when Start && Ready.
- Ready  out  1  high only in IDLE.
- A  in  CHUNK_W*N_CHUNKS  operand A; sampled only on accept.
- B  in  CHUNK_W*N_CHUNKS  operand B; sampled only on accept.
- Cin  in  1  carry-in; sampled only on accept.
- Sum  out  CHUNK_W*N_CHUNKS  result register.
- Cout  out  1  final carry out of the top chunk.
- Overflow  out  1  signed overflow of the full-width result.
- Done  out  1  one-cycle pulse; Sum, Cout and Overflow are valid from this cycle on.

Behaviour:
- Reset (synchronous, active-high) overrides everything, including a mid-operation state:
  - state returns to IDLE, chunk index = 0, Ready=1, Done=0, Sum=0, Cout=0, Overflow=0.
  - A partially computed result is discarded and never flagged Done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Ready=1.
  - On Start, latch A into opa_q, B into opb_q, Cin into carry_q; set idx=0; go to RUN.
  - Start without acceptance has no side effects.
- RUN:
  - Ready=0.
  - Each cycle, the slice adds opa_q[idx], opb_q[idx] and carry_q.
  - The chunk sum is written into Sum[idx*CHUNK_W +: CHUNK_W]; the slice carry-out goes to carry_q.
  - idx increments; when idx==N_CHUNKS-1, go to DONE.
  - Sum chunks above idx keep their old values until overwritten.
- DONE:
  - Done=1 for exactly one cycle; Ready=0.
  - Cout = final carry_q. Overflow = (a_msb == b_msb) && (sum_msb != a_msb), using the effective B after any inversion.
  - Next state is IDLE unconditionally. Start asserted in this cycle is ignored.
- Latency:
  - Accept in cycle t gives Done high in cycle t+N_CHUNKS+1.
  - Back-to-back throughput is one operation per N_CHUNKS+2 cycles.
- Sum, Cout and Overflow hold their values until the next accepted operation begins overwriting them.
- Arithmetic: modulo 2^(CHUNK_W*N_CHUNKS); the carry out of the top chunk is never lost (it goes to Cout).
- Start held high continuously re-issues an operation on every IDLE cycle with the then-current operands.

Optional Feature:
- Macro CSA_SEQ_SUBTRACT_EN.
- Defined:
  - Adds input port Sub (1 bit), sampled on accept.
  - Sub=1 latches ~B and forces carry_q=1, ignoring Cin, giving A-B.
  - Cout=1 means no borrow. Overflow uses the inverted B MSB.
- Undefined:
  - No Sub port; add only.
  - Logic is identical to Sub tied 0.

Decomposition:
- Shared package csa_pkg holds:
  - CHUNK_W constant.
  - FSM state enum type (IDLE/RUN/DONE, 2-bit encoding).
  - Index width function clog2(N_CHUNKS).
- One sub-module: csa_slice8, an 8-bit carry-select adder.
  - Low nibble is rippled; high nibble is computed for carry-in 0 and 1 and selected by the low nibble's carry.
  - Exposes Cout, which the sequencer needs.
  - Purely combinational; instantiated once.

Test Plan:
1. Basic add: A=0x0000_00FF, B=0x0000_0001, Cin=0 -> Done at accept+5, Sum=0x0000_0100, Cout=0, Overflow=0.
2. Full carry chain: A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 -> Sum=0x0000_0000, Cout=1, Overflow=0.
3. Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001 -> Sum=0x8000_0000, Overflow=1, Cout=0. Then, with CSA_SEQ_SUBTRACT_EN, Sub=1, A=0x0000_0005, B=0x0000_0007 -> Sum=0xFFFF_FFFE, Cout=0.
4. Busy ignore: pulse Start with A=B=0x1111_1111 in RUN and DONE cycles -> no effect, Ready low, result from the original operands only, a single Done pulse.
5. Reset mid-op: assert Reset in the 2nd RUN cycle -> next cycle Ready=1, Sum=0, no Done. A following op A=3, B=4 gives Sum=7.
6. Back-to-back: Start held high with 3 operand sets -> Done pulses spaced exactly 6 cycles apart, each result correct.
